// File: rtl/fifo_wr_pkg.sv
// Shared types and default widths for the async FIFO write-domain adapter.
package fifo_wr_pkg;

  localparam int unsigned DEF_DATA_LINES = 8;
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_PKT_W      = 16;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} wr_occ_e;

  // Skid entry layout at the default data width.
  typedef struct packed {
    logic [DEF_DATA_LINES-1:0] data;
    logic                      last;
  } wr_entry_t;

endpackage

// File: rtl/fifo_wr_stats.sv
// Saturating write, packet and full-stall counters for fifo_wr_adapter.
module fifo_wr_stats
  import fifo_wr_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PKT_W = DEF_PKT_W
) (
  input  logic             i_wclk,
  input  logic             i_wrst,
  input  logic             i_write,
  input  logic             i_last,
  input  logic             i_pend_full,
  input  logic             i_half_full,
  output logic [CNT_W-1:0] o_words,
  output logic [PKT_W-1:0] o_pkts,
  output logic [CNT_W-1:0] o_full_cyc
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PKT_W-1:0] PktOne = {{(PKT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_words;
  logic [PKT_W-1:0] r_pkts;
  logic [CNT_W-1:0] r_full_cyc;
  logic             r_half_full;
  logic             w_unused;

  always_ff @(posedge i_wclk or negedge i_wrst) begin
    if (!i_wrst) begin
      r_words     <= '0;
      r_pkts      <= '0;
      r_full_cyc  <= '0;
      r_half_full <= 1'b0;
    end else begin
      if (i_write && (r_words != '1)) r_words <= r_words + CntOne;
      if (i_write && i_last && (r_pkts != '1)) r_pkts <= r_pkts + PktOne;
      if (i_pend_full && (r_full_cyc != '1)) r_full_cyc <= r_full_cyc + CntOne;
      r_half_full <= i_half_full;
    end
  end

  // half_full is sampled for a future threshold counter; nothing counts it yet.
  assign w_unused   = r_half_full;

  assign o_words    = r_words;
  assign o_pkts     = r_pkts;
  assign o_full_cyc = r_full_cyc;

endmodule

// File: rtl/fifo_wr_adapter.sv
// Valid/ready to FIFO write-port adapter with a 2-entry skid buffer.
// Define FIFO_WR_STATS_EN to build the statistics counters.
module fifo_wr_adapter
  import fifo_wr_pkg::*;
#(
  parameter int unsigned DATA_LINES = DEF_DATA_LINES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PKT_W      = DEF_PKT_W
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_LINES-1:0] s_data,
  input  logic                  s_last,
  output logic                  winc,
  output logic [DATA_LINES-1:0] wdata,
  input  logic                  wfull,
  input  logic                  half_full,
  output logic [CNT_W-1:0]      stat_words,
  output logic [PKT_W-1:0]      stat_pkts,
  output logic [CNT_W-1:0]      stat_full_cyc
);

  wr_occ_e               r_state;
  logic                  r_s_ready;
  logic [DATA_LINES-1:0] r_e0_data;
  logic [DATA_LINES-1:0] r_e1_data;

  logic w_accept;
  logic w_write;
  logic w_ld_e0;
  logic w_ld_e1;
  logic w_shift;
  logic w_ready_d;

  assign w_accept  = s_valid & r_s_ready;
  assign w_write   = (r_state != EMPTY) & ~wfull;
  assign w_ld_e0   = w_accept & ((r_state == EMPTY) | ((r_state == ONE) & w_write));
  assign w_ld_e1   = w_accept & (r_state == ONE) & ~w_write;
  assign w_shift   = (r_state == TWO) & w_write;
  // Ready falls only when the next state is TWO.
  assign w_ready_d = ~(w_ld_e1 | ((r_state == TWO) & ~w_write));

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_state   <= EMPTY;
      r_s_ready <= 1'b0;
      r_e0_data <= '0;
      r_e1_data <= '0;
    end else begin
      r_s_ready <= w_ready_d;
      if (w_ld_e0) r_e0_data <= s_data;
      else if (w_shift) r_e0_data <= r_e1_data;
      if (w_ld_e1) r_e1_data <= s_data;
      case (r_state)
        EMPTY:   if (w_accept) r_state <= ONE;
        ONE: begin
          if (w_accept && !w_write) r_state <= TWO;
          else if (!w_accept && w_write) r_state <= EMPTY;
        end
        TWO:     if (w_write) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign winc    = w_write;
  assign wdata   = r_e0_data;

`ifdef FIFO_WR_STATS_EN
  logic r_e0_last;
  logic r_e1_last;

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_e0_last <= 1'b0;
      r_e1_last <= 1'b0;
    end else begin
      if (w_ld_e0) r_e0_last <= s_last;
      else if (w_shift) r_e0_last <= r_e1_last;
      if (w_ld_e1) r_e1_last <= s_last;
    end
  end

  fifo_wr_stats #(
    .CNT_W (CNT_W),
    .PKT_W (PKT_W)
  ) u_stats (
    .i_wclk      (wclk),
    .i_wrst      (wrst),
    .i_write     (w_write),
    .i_last      (r_e0_last),
    .i_pend_full ((r_state != EMPTY) & wfull),
    .i_half_full (half_full),
    .o_words     (stat_words),
    .o_pkts      (stat_pkts),
    .o_full_cyc  (stat_full_cyc)
  );
`else
  logic w_unused;

  assign w_unused      = ^{s_last, half_full};
  assign stat_words    = '0;
  assign stat_pkts     = '0;
  assign stat_full_cyc = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed self-checking bench for fifo_wr_adapter (either build of FIFO_WR_STATS_EN).
module tb_fifo_wr_adapter;

  logic        wclk      = 1'b0;
  logic        wrst      = 1'b0;
  logic        s_valid   = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data    = 8'h00;
  logic        s_last    = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull     = 1'b0;
  logic        half_full = 1'b0;
  logic [31:0] stat_words;
  logic [15:0] stat_pkts;
  logic [31:0] stat_full_cyc;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FIFO_WR_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  fifo_wr_adapter dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .half_full     (half_full),
    .stat_words    (stat_words),
    .stat_pkts     (stat_pkts),
    .stat_full_cyc (stat_full_cyc)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] es(input logic [31:0] v);
    return Stats ? v : 32'd0;
  endfunction

  // Scoreboard: accepted words must come out of wdata in order, never under wfull.
  logic [7:0] aq[$];
  int wr_cnt   = 0;
  int exp_full = 0;
  int run_len  = 0;

  always @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      aq.delete();
      wr_cnt   = 0;
      exp_full = 0;
      run_len  = 0;
    end else begin
      if (aq.size() > 0 && wfull) exp_full++;
      check("no_winc_while_full", {31'd0, winc & wfull}, 32'd0);
      if (winc) begin
        if (aq.size() == 0) check("write_with_nothing_pending", 32'd1, 32'd0);
        else check("wdata_order", {24'd0, wdata}, {24'd0, aq.pop_front()});
        wr_cnt++;
        run_len++;
      end else begin
        run_len = 0;
      end
      if (s_valid && s_ready) aq.push_back(s_data);
    end
  end

  // Offer one word and wait for its accept edge; returns at accept edge + 1.
  task automatic push(input logic [7:0] d, input logic l, output int cyc);
    bit acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    cyc     = 0;
    acc     = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge wclk);
      acc = s_ready;
      @(posedge wclk);
      #1;
      cyc++;
    end
    if (!acc) check("push_timeout", cyc, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    wrst = 1'b0;
    #1;
    check({tag, "_winc"}, {31'd0, winc}, 32'd0);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_stat_words"}, stat_words, 32'd0);
    check({tag, "_stat_pkts"}, {16'd0, stat_pkts}, 32'd0);
    check({tag, "_stat_full"}, stat_full_cyc, 32'd0);
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b1;
    @(posedge wclk);
    #1;
    check({tag, "_ready_after_release"}, {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int tot;

    // Reset values.
    #12;
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_winc", {31'd0, winc}, 32'd0);
    check("rst_wdata", {24'd0, wdata}, 32'd0);
    check("rst_stat_words", stat_words, 32'd0);
    check("rst_stat_full", stat_full_cyc, 32'd0);
    @(negedge wclk);
    wrst = 1'b1;
    #1;
    check("ready_before_first_edge", {31'd0, s_ready}, 32'd0);
    @(posedge wclk);
    #1;
    check("ready_one_edge_after_release", {31'd0, s_ready}, 32'd1);

    // Streaming 0x01..0x10 at one word per cycle.
    tot = 0;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), 1'b0, cyc);
      tot += cyc;
    end
    s_valid = 1'b0;
    check("stream_accept_cycles", tot, 32'd16);
    check("stream_last_winc", {31'd0, winc}, 32'd1);
    check("stream_last_wdata", {24'd0, wdata}, 32'h10);
    @(posedge wclk);
    #1;
    check("stream_consecutive_winc", run_len, 32'd16);
    check("stream_wr_cnt", wr_cnt, 32'd16);
    check("stream_stat_words", stat_words, es(32'd16));
    check("stream_idle_winc", {31'd0, winc}, 32'd0);

    // Back-pressure: two words absorbed, third held upstream.
    wfull = 1'b1;
    push(8'hA0, 1'b0, cyc);
    check("bp_a0_cycles", cyc, 32'd1);
    push(8'hA1, 1'b0, cyc);
    check("bp_a1_cycles", cyc, 32'd1);
    check("bp_ready_low", {31'd0, s_ready}, 32'd0);
    s_data = 8'hA2;
    repeat (3) @(posedge wclk);
    #1;
    check("bp_ready_held_low", {31'd0, s_ready}, 32'd0);
    check("bp_winc_low", {31'd0, winc}, 32'd0);
    check("bp_no_writes", wr_cnt, 32'd16);
    check("bp_head_held", {24'd0, wdata}, 32'hA0);
    wfull = 1'b0;
    #1;
    check("bp_winc_same_cycle", {31'd0, winc}, 32'd1);
    check("bp_head_a0", {24'd0, wdata}, 32'hA0);
    push(8'hA2, 1'b0, cyc);
    s_valid = 1'b0;
    check("bp_a2_head", {24'd0, wdata}, 32'hA2);
    @(posedge wclk);
    #1;
    check("bp_no_gap", run_len, 32'd3);
    check("bp_wr_cnt", wr_cnt, 32'd19);
    check("bp_stat_full", stat_full_cyc, es(32'd4));

    // wfull toggling every cycle during a 20-word stream.
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 20; i++) push(8'h40 + 8'(i), 1'b0, cyc);
          s_valid = 1'b0;
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge wclk);
            #1;
            wfull = ~wfull;
          end
        end
      join
    end
    wfull = 1'b0;
    repeat (4) @(posedge wclk);
    #1;
    check("tog_all_written", wr_cnt, 32'd39);
    check("tog_nothing_pending", aq.size(), 32'd0);
    check("tog_stat_words", stat_words, es(32'd39));
    check("tog_stat_full", stat_full_cyc, es(32'(exp_full)));

    // Reset with two words buffered; stale words must not be written.
    wfull = 1'b1;
    push(8'hB0, 1'b0, cyc);
    push(8'hB1, 1'b0, cyc);
    s_valid = 1'b0;
    check("mid_rst_two_buffered", {31'd0, s_ready}, 32'd0);
    wfull = 1'b0;
    do_reset("mid_rst");
    check("mid_rst_no_stale", {31'd0, winc}, 32'd0);
    push(8'hC0, 1'b0, cyc);
    s_valid = 1'b0;
    check("mid_rst_first_word", {24'd0, wdata}, 32'hC0);
    check("mid_rst_first_winc", {31'd0, winc}, 32'd1);
    @(posedge wclk);
    #1;
    check("mid_rst_wr_cnt", wr_cnt, 32'd1);
    check("mid_rst_stat_words", stat_words, es(32'd1));

    // Packets of length 1, 4 and 7.
    do_reset("pkt_rst");
    for (int p = 0; p < 3; p++) begin
      int len;
      len = (p == 0) ? 1 : ((p == 1) ? 4 : 7);
      for (int k = 0; k < len; k++) push(8'h80 + 8'(p * 16 + k), (k == len - 1), cyc);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check("pkt_wr_cnt", wr_cnt, 32'd12);
    check("pkt_stat_words", stat_words, es(32'd12));
    check("pkt_stat_pkts", {16'd0, stat_pkts}, es(32'd3));
    check("pkt_stat_full", stat_full_cyc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
